// File: rtl/gpio_pwm_pkg.sv
// Shared encodings for the GPIO/PWM bank: channel modes and register field selectors.
package gpio_pwm_pkg;

  // Per-channel output engine mode.
  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_PWM     = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_t;

  // Register field selector, the low two bits of the request address.
  localparam logic [1:0] FLD_DATA   = 2'd0;
  localparam logic [1:0] FLD_DUTY   = 2'd1;
  localparam logic [1:0] FLD_MODE   = 2'd2;
  localparam logic [1:0] FLD_STATUS = 2'd3;

endpackage

// File: rtl/pwm_channel.sv
// One output channel: DUTY and MODE registers plus the PWM / BLINK / ONESHOT engine.
// Ports: clk, rst (async, active-high); tick/wrap/cnt from the shared timebase;
//        duty_we/duty_wdata and mode_we/mode_wdata host write strobes;
//        duty, mode register read-back; pwm registered pin output.
module pwm_channel
  import gpio_pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             wrap,
  input  logic [CNT_W-1:0] cnt,
  input  logic             duty_we,
  input  logic [CNT_W-1:0] duty_wdata,
  input  logic             mode_we,
  input  mode_t            mode_wdata,
  output logic [CNT_W-1:0] duty,
  output mode_t            mode,
  output logic             pwm
);

  logic [CNT_W-1:0] duty_n;
  mode_t            mode_n;
  logic             toggle, toggle_n;
  logic [CNT_W-1:0] os_cnt, os_n;
  logic             pwm_n;

  // Next state; pwm is derived from next state so host writes show on the pin one cycle later.
  always_comb begin
    duty_n   = duty_we ? duty_wdata : duty;
    mode_n   = mode;
    os_n     = os_cnt;
    toggle_n = toggle ^ wrap;
    pwm_n    = 1'b0;
    if (mode_we) begin
      // Host write beats the oneshot auto-clear; a zero-length oneshot lands directly in OFF.
      mode_n   = mode_wdata;
      os_n     = duty;
      toggle_n = 1'b0;
      if (mode_wdata == MODE_ONESHOT && duty == '0) begin
        mode_n = MODE_OFF;
      end
    end else if (mode == MODE_ONESHOT) begin
      if (tick && os_cnt != '0) begin
        os_n = os_cnt - CNT_W'(1);
      end
      if (os_n == '0) begin
        mode_n = MODE_OFF;
      end
    end
    case (mode_n)
      MODE_PWM:     pwm_n = (cnt < duty_n);
      MODE_BLINK:   pwm_n = toggle_n;
      MODE_ONESHOT: pwm_n = (os_n != '0);
      default:      pwm_n = 1'b0;
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty   <= '0;
      mode   <= MODE_OFF;
      toggle <= 1'b0;
      os_cnt <= '0;
      pwm    <= 1'b0;
    end else begin
      duty   <= duty_n;
      mode   <= mode_n;
      toggle <= toggle_n;
      os_cnt <= os_n;
      pwm    <= pwm_n;
    end
  end

endmodule

// File: rtl/gpio_pwm_bank.sv
// Multi-channel GPIO DATA registers with per-channel PWM/BLINK/ONESHOT pins behind a
// one-outstanding valid/ready register port.
// Ports: clk, rst (async, active-high); req_valid/req_ready/req_write/req_addr/req_wdata
//        request channel; rsp_valid/rsp_ready/rsp_rdata/rsp_err response channel;
//        gpio_out concatenated DATA registers (channel 0 at LSBs); pwm_out one pin per channel.
module gpio_pwm_bank
  import gpio_pwm_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned PRESC_DIV = 1,
  localparam int unsigned AW = $clog2(NUM_CH) + 2,
  localparam int unsigned RW = (DW > CNT_W) ? DW : CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [AW-1:0]        req_addr,
  input  logic [RW-1:0]        req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [RW-1:0]        rsp_rdata,
  output logic                 rsp_err,
  output logic [NUM_CH*DW-1:0] gpio_out,
  output logic [NUM_CH-1:0]    pwm_out
);

  localparam int unsigned PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

  logic [PW-1:0]    presc;
  logic [CNT_W-1:0] cnt;
  logic             tick, wrap;
  logic [DW-1:0]    data_q [NUM_CH];
  logic [CNT_W-1:0] duty_a [NUM_CH];
  mode_t            mode_a [NUM_CH];

  logic             accept;
  logic [AW-1:0]    ch_idx;
  logic [1:0]       fld;
  logic             ch_ok;
  logic [NUM_CH-1:0] data_we, duty_we, mode_we;
  logic [RW-1:0]    rd_c;
  logic             err_c;

  assign req_ready = !rsp_valid | rsp_ready;
  assign accept    = req_valid & req_ready;
  assign ch_idx    = AW'(req_addr >> 2);
  assign fld       = req_addr[1:0];
  assign ch_ok     = (ch_idx < AW'(NUM_CH));
  assign err_c     = !ch_ok | (req_write & (fld == FLD_STATUS));
  assign tick      = (presc == PW'(PRESC_DIV - 1));
  assign wrap      = tick & (cnt == '1);

  // Address decode: write strobes and read mux; out-of-range channels read as zero.
  always_comb begin
    data_we = '0;
    duty_we = '0;
    mode_we = '0;
    rd_c    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == AW'(i)) begin
        data_we[i] = accept & req_write & (fld == FLD_DATA);
        duty_we[i] = accept & req_write & (fld == FLD_DUTY);
        mode_we[i] = accept & req_write & (fld == FLD_MODE);
        case (fld)
          FLD_DATA: rd_c = RW'(data_q[i]);
          FLD_DUTY: rd_c = RW'(duty_a[i]);
          FLD_MODE: rd_c = RW'(mode_a[i]);
          default:  rd_c = RW'(cnt);
        endcase
      end
    end
  end

  // Shared timebase: prescaler and free-running PWM counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      cnt   <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // DATA registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (data_we[i]) data_q[i] <= req_wdata[DW-1:0];
      end
    end
  end

  // Response register: loaded on accept, held until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= (req_write || err_c) ? '0 : rd_c;
      rsp_err   <= err_c;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Per-channel engines and GPIO bus.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign gpio_out[g*DW +: DW] = data_q[g];

    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .wrap       (wrap),
      .cnt        (cnt),
      .duty_we    (duty_we[g]),
      .duty_wdata (req_wdata[CNT_W-1:0]),
      .mode_we    (mode_we[g]),
      .mode_wdata (mode_t'(req_wdata[1:0])),
      .duty       (duty_a[g]),
      .mode       (mode_a[g]),
      .pwm        (pwm_out[g])
    );
  end

endmodule
